// File: rtl/vram_defs_pkg.sv
// Shared constants, register map and FSM encoding for the VRAM port-B fill scheduler.
package vram_defs;

    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned DATA_W_DEF     = 8;
    localparam int unsigned VRAM_DEPTH_DEF = 38400;
    localparam int unsigned BYTES_PER_ROW  = 80;
    localparam int unsigned LEN_W          = 17;
    localparam int unsigned FILL_W         = 8;
    localparam int unsigned CFG_W          = 32;

    localparam logic [1:0] SEL_START = 2'd0;
    localparam logic [1:0] SEL_LEN   = 2'd1;
    localparam logic [1:0] SEL_FILL  = 2'd2;
    localparam logic [1:0] SEL_CTRL  = 2'd3;

    localparam int unsigned CTRL_START_BIT = 0;
    localparam int unsigned CTRL_ABORT_BIT = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/vram_fill_regs.sv
// Bus-mapped START/LEN/FILL/CTRL registers, CTRL strobe decode and read mux
// for the VRAM fill engine.
module vram_fill_regs
    import vram_defs::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cfg_we,
    input  logic [1:0]        i_cfg_sel,
    input  logic [CFG_W-1:0]  i_cfg_wdata,
    output logic [CFG_W-1:0]  o_cfg_rdata,
    input  logic              i_idle,
    input  logic              i_busy,
    input  logic              i_done_set,
    input  logic              i_err_set,
    output logic [ADDR_W-1:0] o_start,
    output logic [LEN_W-1:0]  o_len,
    output logic [FILL_W-1:0] o_fill,
    output logic              o_go_c,
    output logic              o_abort_c
);

    logic [ADDR_W-1:0] r_start;
    logic [LEN_W-1:0]  r_len;
    logic [FILL_W-1:0] r_fill;
    logic              r_done;
    logic              r_err;
    logic              w_cfg_wr;
    logic              w_ctrl_wr;
    logic              w_unused;

    // Configuration is frozen outside IDLE; abort beats start in the same write.
    assign w_cfg_wr  = i_cfg_we && i_idle;
    assign w_ctrl_wr = i_cfg_we && (i_cfg_sel == SEL_CTRL);
    assign o_abort_c = w_ctrl_wr && i_cfg_wdata[CTRL_ABORT_BIT];
    assign o_go_c    = w_ctrl_wr && i_cfg_wdata[CTRL_START_BIT]
                       && !i_cfg_wdata[CTRL_ABORT_BIT] && i_idle;
    assign w_unused  = ^i_cfg_wdata[CFG_W-1:LEN_W];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_start <= '0;
            r_len   <= '0;
            r_fill  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_cfg_wr && (i_cfg_sel == SEL_START)) r_start <= i_cfg_wdata[ADDR_W-1:0];
            if (w_cfg_wr && (i_cfg_sel == SEL_LEN))   r_len   <= i_cfg_wdata[LEN_W-1:0];
            if (w_cfg_wr && (i_cfg_sel == SEL_FILL))  r_fill  <= i_cfg_wdata[FILL_W-1:0];
            r_done <= i_done_set ? 1'b1 : (o_go_c ? 1'b0 : r_done);
            r_err  <= i_err_set  ? 1'b1 : (o_go_c ? 1'b0 : r_err);
        end
    end

    always_comb begin
        o_cfg_rdata = '0;
        case (i_cfg_sel)
            SEL_START: o_cfg_rdata = CFG_W'(r_start);
            SEL_LEN:   o_cfg_rdata = CFG_W'(r_len);
            SEL_FILL:  o_cfg_rdata = CFG_W'(r_fill);
            default:   o_cfg_rdata = CFG_W'({r_err, r_done, i_busy});
        endcase
    end

    assign o_start = r_start;
    assign o_len   = r_len;
    assign o_fill  = r_fill;

endmodule

// File: rtl/vram_fill_sched.sv
// VRAM port-B arbiter: scanout reads always win, the block-fill engine writes
// one byte on every cycle scanout leaves the port free.
module vram_fill_sched
    import vram_defs::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned VRAM_DEPTH = VRAM_DEPTH_DEF
) (
    input  logic              mclk,
    input  logic              resetn,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_sel,
    input  logic [CFG_W-1:0]  cfg_wdata,
    output logic [CFG_W-1:0]  cfg_rdata,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data,
    output logic [ADDR_W-1:0] vram_addrb,
    output logic              vram_web,
    output logic [DATA_W-1:0] vram_dinb,
    input  logic [DATA_W-1:0] vram_doutb,
    output logic              busy,
    output logic              done_pulse
);

    localparam int unsigned SUM_W = LEN_W + 1;

    fill_state_e       r_state;
    fill_state_e       w_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] w_start;
    logic [LEN_W-1:0]  w_len;
    logic [FILL_W-1:0] w_fill;
    logic              w_go;
    logic              w_abort;
    logic              w_grant;
    logic              w_range_err;
    logic              w_err_set;

    assign w_grant   = !scan_req;
    assign scan_data = vram_doutb;

    // One bit wider than LEN so a large START+LEN can never wrap past the check.
    assign w_range_err = (SUM_W'(w_start) + SUM_W'(w_len)) > SUM_W'(VRAM_DEPTH);
    assign w_err_set   = w_go && (w_len != '0) && w_range_err;

    vram_fill_regs #(
        .ADDR_W (ADDR_W)
    ) u_regs (
        .i_clk       (mclk),
        .i_rst_n     (resetn),
        .i_cfg_we    (cfg_we),
        .i_cfg_sel   (cfg_sel),
        .i_cfg_wdata (cfg_wdata),
        .o_cfg_rdata (cfg_rdata),
        .i_idle      (r_state == ST_IDLE),
        .i_busy      (busy),
        .i_done_set  (r_state == ST_DONE),
        .i_err_set   (w_err_set),
        .o_start     (w_start),
        .o_len       (w_len),
        .o_fill      (w_fill),
        .o_go_c      (w_go),
        .o_abort_c   (w_abort)
    );

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    if (w_len == '0)       w_next = ST_DONE;
                    else if (!w_range_err) w_next = ST_FILL;
                end
            end
            ST_FILL: begin
                if (w_abort)                              w_next = ST_IDLE;
                else if (w_grant && (r_cnt == LEN_W'(1))) w_next = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Write pointer and remaining count advance only on granted fill cycles.
    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (w_go) begin
            r_ptr <= w_start;
            r_cnt <= w_len;
        end else if ((r_state == ST_FILL) && w_grant) begin
            r_ptr <= r_ptr + ADDR_W'(1);
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    always_comb begin
        vram_web   = 1'b0;
        vram_addrb = scan_addr;
        vram_dinb  = DATA_W'(w_fill);
        busy       = 1'b0;
        done_pulse = 1'b0;
        case (r_state)
            ST_FILL: begin
                busy = 1'b1;
                if (w_grant) begin
                    vram_web   = 1'b1;
                    vram_addrb = r_ptr;
                end
            end
            ST_DONE: begin
                busy       = 1'b1;
                done_pulse = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_vram_fill_sched.sv
// Self-checking bench for vram_fill_sched: randomized fills and stalls checked
// against a write-list model derived from START/LEN/FILL and the scan pattern.
module tb_vram_fill_sched;
    import vram_defs::*;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 8;
    localparam int          DEPTH = 38400;

    logic          mclk = 1'b0;
    logic          resetn;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [31:0]   cfg_wdata;
    logic [31:0]   cfg_rdata;
    logic          scan_req;
    logic [AW-1:0] scan_addr;
    logic [DW-1:0] scan_data;
    logic [AW-1:0] vram_addrb;
    logic          vram_web;
    logic [DW-1:0] vram_dinb;
    logic [DW-1:0] vram_doutb;
    logic          busy;
    logic          done_pulse;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int s_cyc = 0;
    int stall_bad = 0;
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            done_cyc_q[$];
    bit            pat_q[$];
    bit            scan_pat[$];

    vram_fill_sched dut (
        .mclk       (mclk),
        .resetn     (resetn),
        .cfg_we     (cfg_we),
        .cfg_sel    (cfg_sel),
        .cfg_wdata  (cfg_wdata),
        .cfg_rdata  (cfg_rdata),
        .scan_req   (scan_req),
        .scan_addr  (scan_addr),
        .scan_data  (scan_data),
        .vram_addrb (vram_addrb),
        .vram_web   (vram_web),
        .vram_dinb  (vram_dinb),
        .vram_doutb (vram_doutb),
        .busy       (busy),
        .done_pulse (done_pulse)
    );

    always #5 mclk = ~mclk;
    always @(posedge mclk) cyc <= cyc + 1;

    // Passive recorder of port-B activity, sampled mid-cycle.
    always @(negedge mclk) begin
        if (vram_web === 1'b1) begin
            wr_addr_q.push_back(vram_addrb);
            wr_data_q.push_back(vram_dinb);
        end
        if (scan_req === 1'b1 && (vram_web !== 1'b0 || vram_addrb !== scan_addr)) stall_bad++;
        if (done_pulse === 1'b1) done_cyc_q.push_back(cyc);
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        done_cyc_q.delete();
        pat_q.delete();
        stall_bad = 0;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [31:0] data);
        cfg_we = 1'b1; cfg_sel = sel; cfg_wdata = data;
        @(posedge mclk); #1;
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic rd(input logic [1:0] sel, output logic [31:0] data);
        cfg_sel = sel;
        @(posedge mclk); #1;
        data = cfg_rdata;
    endtask

    // Model: index of the first logged write that is not START+k / FILL, -1 if all match.
    function automatic int first_bad_write(input int start, input logic [7:0] fill, input int n);
        for (int k = 0; k < n && k < wr_addr_q.size(); k++)
            if (wr_addr_q[k] !== AW'(start + k) || wr_data_q[k] !== fill) return k;
        return -1;
    endfunction

    // Model: cycles from the start edge to the DONE cycle given the applied scan pattern.
    function automatic int exp_done_off(input int len);
        int g = 0;
        if (len == 0) return 0;
        for (int k = 0; k < pat_q.size(); k++) begin
            if (!pat_q[k]) g++;
            if (g == len) return k + 1;
        end
        return -1;
    endfunction

    task automatic run_fill(input logic [31:0] start_raw, input logic [31:0] len_raw,
                            input logic [31:0] fill_raw, input int stall_pct, input int bound);
        int i = 0;
        bit sreq;
        cfg_write(SEL_START, start_raw);
        cfg_write(SEL_LEN, len_raw);
        cfg_write(SEL_FILL, fill_raw);
        clear_logs();
        cfg_write(SEL_CTRL, 32'h1);
        s_cyc = cyc;
        while (busy === 1'b1 && i < bound) begin
            sreq = (i < scan_pat.size()) ? scan_pat[i] : (int'($urandom_range(0, 99)) < stall_pct);
            scan_req  = sreq;
            scan_addr = AW'($urandom_range(0, DEPTH - 1));
            pat_q.push_back(sreq);
            @(posedge mclk); #1;
            i++;
        end
        scan_req = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL fill_terminates: busy=%b after %0d cycles, required 0", busy, i);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_wdata = '0;
        scan_req = 1'b0; scan_addr = 16'd1234; vram_doutb = 8'h3C;
        repeat (3) @(posedge mclk);
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_cmp++; if (done_pulse !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b required 0", done_pulse); end
        n_cmp++; if (vram_web !== 1'b0) begin n_bad++; $display("FAIL reset_web: got %b required 0", vram_web); end
        n_cmp++; if (vram_addrb !== 16'd1234) begin n_bad++; $display("FAIL reset_addrb: got %0d required 1234", vram_addrb); end
        n_cmp++; if (scan_data !== 8'h3C) begin n_bad++; $display("FAIL scan_data: got %h required 3c", scan_data); end
        for (int s = 0; s < 4; s++) begin
            cfg_sel = 2'(s);
            @(posedge mclk); #1;
            n_cmp++;
            if (cfg_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_reg%0d: got %h required 0", s, cfg_rdata); end
        end
        resetn = 1'b1;
        @(posedge mclk); #1;
    endtask

    task automatic test_full_clear();
        logic [31:0] d;
        int fb;
        scan_pat.delete();
        run_fill(32'd0, 32'd38400, 32'hFF, 0, 40000);
        fb = first_bad_write(0, 8'hFF, 38400);
        n_cmp++; if (wr_addr_q.size() != 38400) begin n_bad++; $display("FAIL clear_count: got %0d required 38400", wr_addr_q.size()); end
        n_cmp++; if (fb != -1) begin n_bad++; $display("FAIL clear_content: first bad index %0d required none", fb); end
        n_cmp++; if (done_cyc_q.size() != 1) begin n_bad++; $display("FAIL clear_done_count: got %0d required 1", done_cyc_q.size()); end
        else begin
            n_cmp++;
            if (done_cyc_q[0] - s_cyc != 38400) begin n_bad++; $display("FAIL clear_done_cycle: got %0d required 38400", done_cyc_q[0] - s_cyc); end
        end
        rd(SEL_CTRL, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL clear_ctrl: got %h required 2", d); end
    endtask

    task automatic test_stall();
        logic [31:0] d;
        int fb;
        scan_pat = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_fill(32'd100, 32'd4, 32'hA5, 0, 50);
        scan_pat.delete();
        fb = first_bad_write(100, 8'hA5, 4);
        n_cmp++; if (wr_addr_q.size() != 4) begin n_bad++; $display("FAIL stall_count: got %0d required 4", wr_addr_q.size()); end
        n_cmp++; if (fb != -1) begin n_bad++; $display("FAIL stall_content: first bad index %0d required none", fb); end
        n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL stall_port: %0d stalled cycles not on scan_addr, required 0", stall_bad); end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] - s_cyc != exp_done_off(4)) begin
            n_bad++; $display("FAIL stall_done: got %0d pulses, required 1 at offset %0d", done_cyc_q.size(), exp_done_off(4));
        end
        rd(SEL_CTRL, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL stall_ctrl: got %h required 2", d); end
    endtask

    task automatic test_len_zero();
        logic [31:0] d;
        run_fill(32'd500, 32'd0, 32'h11, 0, 10);
        n_cmp++; if (wr_addr_q.size() != 0) begin n_bad++; $display("FAIL len0_writes: got %0d required 0", wr_addr_q.size()); end
        n_cmp++;
        if (done_cyc_q.size() != 1 || done_cyc_q[0] != s_cyc) begin
            n_bad++; $display("FAIL len0_done: got %0d pulses, required 1 in the cycle after start", done_cyc_q.size());
        end
        rd(SEL_CTRL, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL len0_ctrl: got %h required 2", d); end
    endtask

    task automatic test_range_err();
        logic [31:0] d;
        int fb;
        run_fill(32'd38399, 32'd2, 32'h77, 0, 10);
        n_cmp++; if (wr_addr_q.size() != 0) begin n_bad++; $display("FAIL err_writes: got %0d required 0", wr_addr_q.size()); end
        n_cmp++; if (done_cyc_q.size() != 0) begin n_bad++; $display("FAIL err_done: got %0d pulses required 0", done_cyc_q.size()); end
        rd(SEL_CTRL, d);
        n_cmp++; if (d !== 32'h4) begin n_bad++; $display("FAIL err_ctrl: got %h required 4", d); end
        // Exactly reaching the end of VRAM is legal.
        run_fill(32'd38398, 32'd2, 32'h5A, 30, 100);
        fb = first_bad_write(38398, 8'h5A, 2);
        n_cmp++;
        if (wr_addr_q.size() != 2 || fb != -1) begin
            n_bad++; $display("FAIL edge_fill: got %0d writes (bad idx %0d) required 2 correct", wr_addr_q.size(), fb);
        end
        rd(SEL_CTRL, d);
        n_cmp++; if (d !== 32'h2) begin n_bad++; $display("FAIL edge_ctrl: got %h required 2", d); end
    endtask

    task automatic test_abort();
        logic [31:0] d;
        int fb;
        cfg_write(SEL_START, 32'd2000);
        cfg_write(SEL_LEN, 32'd1000);
        cfg_write(SEL_FILL, 32'h3E);
        clear_logs();
        scan_req = 1'b0;
        cfg_write(SEL_CTRL, 32'h1);
        cfg_write(SEL_FILL, 32'h00);
        cfg_write(SEL_START, 32'd0);
        cfg_write(SEL_CTRL, 32'h1);
        repeat (7) begin
            scan_addr = AW'($urandom_range(0, DEPTH - 1));
            @(posedge mclk); #1;
        end
        scan_req = 1'b1;
        cfg_write(SEL_CTRL, 32'h2);
        scan_req = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        fb = first_bad_write(2000, 8'h3E, 10);
        n_cmp++; if (wr_addr_q.size() != 10) begin n_bad++; $display("FAIL abort_count: got %0d required 10", wr_addr_q.size()); end
        n_cmp++; if (fb != -1) begin n_bad++; $display("FAIL abort_content: first bad index %0d required none", fb); end
        n_cmp++; if (done_cyc_q.size() != 0) begin n_bad++; $display("FAIL abort_done: got %0d pulses required 0", done_cyc_q.size()); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %b required 0", busy); end
        rd(SEL_CTRL, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL abort_ctrl: got %h required 0", d); end
        rd(SEL_START, d);
        n_cmp++; if (d !== 32'd2000) begin n_bad++; $display("FAIL busy_write_ignored: START got %0d required 2000", d); end
        cfg_write(SEL_START, 32'd777);
        rd(SEL_START, d);
        n_cmp++; if (d !== 32'd777) begin n_bad++; $display("FAIL start_after_abort: got %0d required 777", d); end
        cfg_write(SEL_CTRL, 32'h3);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL abort_beats_start: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] d;
        int guard = 0;
        int fb;
        cfg_write(SEL_START, 32'd300);
        cfg_write(SEL_LEN, 32'd50);
        cfg_write(SEL_FILL, 32'hC3);
        clear_logs();
        scan_req = 1'b0;
        cfg_write(SEL_CTRL, 32'h1);
        while (wr_addr_q.size() < 5 && guard < 20) begin
            @(posedge mclk); #1;
            guard++;
        end
        n_cmp++; if (vram_web !== 1'b1) begin n_bad++; $display("FAIL prereset_web: got %b required 1", vram_web); end
        #1 resetn = 1'b0;
        #1;
        n_cmp++; if (vram_web !== 1'b0) begin n_bad++; $display("FAIL async_web: got %b required 0", vram_web); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL async_busy: got %b required 0", busy); end
        for (int s = 0; s < 4; s++) begin
            cfg_sel = 2'(s);
            @(posedge mclk); #1;
            n_cmp++;
            if (cfg_rdata !== 32'd0) begin n_bad++; $display("FAIL midreset_reg%0d: got %h required 0", s, cfg_rdata); end
        end
        n_cmp++; if (wr_addr_q.size() != 5) begin n_bad++; $display("FAIL midreset_count: got %0d required 5", wr_addr_q.size()); end
        resetn = 1'b1;
        @(posedge mclk); #1;
        run_fill(32'd7, 32'd3, 32'h81, 20, 50);
        fb = first_bad_write(7, 8'h81, 3);
        n_cmp++;
        if (wr_addr_q.size() != 3 || fb != -1 || done_cyc_q.size() != 1) begin
            n_bad++; $display("FAIL post_reset_fill: got %0d writes, %0d pulses, required 3 and 1", wr_addr_q.size(), done_cyc_q.size());
        end
    endtask

    task automatic test_random();
        logic [31:0] r, d;
        int len, start, fill, exp_n, exp_done, exp_err, fb;
        for (int it = 0; it < 20; it++) begin
            len = int'($urandom_range(0, 300));
            if ($urandom_range(0, 2) == 0) start = int'($urandom_range(0, DEPTH - 1));
            else start = DEPTH - len + int'($urandom_range(0, 2)) - 1;
            if (start < 0) start = 0;
            fill = int'($urandom_range(0, 255));
            exp_err  = (len != 0 && start + len > DEPTH) ? 1 : 0;
            exp_n    = (exp_err == 1) ? 0 : len;
            exp_done = (exp_err == 1) ? 0 : 1;
            r = $urandom;
            run_fill({r[31:16], 16'(start)}, {r[31:17], 17'(len)}, {r[31:8], 8'(fill)}, 40, 2000);
            fb = first_bad_write(start, 8'(fill), exp_n);
            n_cmp++;
            if (wr_addr_q.size() != exp_n || fb != -1) begin
                n_bad++; $display("FAIL rnd%0d_writes: got %0d (bad idx %0d) required %0d at %0d", it, wr_addr_q.size(), fb, exp_n, start);
            end
            n_cmp++;
            if (done_cyc_q.size() != exp_done) begin
                n_bad++; $display("FAIL rnd%0d_done: got %0d pulses required %0d", it, done_cyc_q.size(), exp_done);
            end else if (exp_done == 1 && done_cyc_q[0] - s_cyc != exp_done_off(len)) begin
                n_bad++; $display("FAIL rnd%0d_done_cycle: got %0d required %0d", it, done_cyc_q[0] - s_cyc, exp_done_off(len));
            end
            n_cmp++;
            if (stall_bad != 0) begin n_bad++; $display("FAIL rnd%0d_stall_port: got %0d bad cycles required 0", it, stall_bad); end
            rd(SEL_CTRL, d);
            n_cmp++;
            if (d !== 32'(exp_err * 4 + exp_done * 2)) begin
                n_bad++; $display("FAIL rnd%0d_ctrl: got %h required %h", it, d, exp_err * 4 + exp_done * 2);
            end
            rd(SEL_LEN, d);
            n_cmp++;
            if (d !== 32'(len)) begin n_bad++; $display("FAIL rnd%0d_len_rd: got %0d required %0d", it, d, len); end
        end
    endtask

    initial begin
        test_reset();
        test_full_clear();
        test_stall();
        test_len_zero();
        test_range_err();
        test_abort();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
